// File: rtl/ram_pkg.sv
// Shared constants, types and the parity helper for the 64K x 32 RAM.
package ram_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(data_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_2_16x32_array.sv
// Bare storage array: synchronous write, unregistered read, shaped for block-RAM inference.
module ram_2_16x32_array
  import ram_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset on purpose; a reset loop over 64K words
  // would prevent block-RAM inference and nothing depends on its contents.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_2_16x32.sv
// Single-port 64K x 32 synchronous RAM with registered read output and write-first
// same-edge bypass. Optional stored even parity and parity_err output: `define RAM_PARITY_EN.
module ram_2_16x32
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_input,
  output logic [DATA_W-1:0] data_output
`ifdef RAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic             w_we;
  logic [MEM_W-1:0] w_wdata;
  logic [MEM_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_data;

  // Edges that arrive while reset is held must not touch memory.
  assign w_we = write_enable & rst;

`ifdef RAM_PARITY_EN
  assign w_wdata = {even_parity(data_input), data_input};
`else
  assign w_wdata = data_input;
`endif

  ram_2_16x32_array #(.WIDTH(MEM_W)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (address),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // NOTE: the array updates on the same edge with a non-blocking write, so its
  // read port still shows the old word; write-first must bypass from data_input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (read_enable) begin
      r_data <= write_enable ? data_input : w_rdata[DATA_W-1:0];
    end
  end

  assign data_output = r_data;

`ifdef RAM_PARITY_EN
  logic r_perr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perr <= 1'b0;
    end else if (read_enable) begin
      r_perr <= write_enable ? 1'b0
                             : (even_parity(w_rdata[DATA_W-1:0]) != w_rdata[DATA_W]);
    end
  end

  assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_ram_2_16x32.sv
// Directed self-checking bench for ram_2_16x32; parity checks build with RAM_PARITY_EN.
module tb_ram_2_16x32;
  import ram_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              write_enable;
  logic              read_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_input;
  logic [DATA_W-1:0] data_output;
`ifdef RAM_PARITY_EN
  logic              parity_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ram_2_16x32 dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .data_input   (data_input),
    .data_output  (data_output)
`ifdef RAM_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    write_enable = we;
    read_enable  = re;
    address      = a;
    data_input   = d;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b1, 16'd66, 32'd0);
    #1;
    check("reset_async", data_output, 32'd0);
    step();
    check("reset_cyc1", data_output, 32'd0);
    step();
    check("reset_cyc2", data_output, 32'd0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'd66, 32'd0);
    step();
    check("post_reset_idle", data_output, 32'd0);

    // Write 20 to 66, then read it.
    drive(1'b1, 1'b0, 16'd66, 32'd20);
    step();
    check("write_no_output", data_output, 32'd0);
    drive(1'b0, 1'b1, 16'd66, 32'd0);
    step();
    check("read_66", data_output, 32'd20);
    drive(1'b0, 1'b0, 16'd7, 32'd0);
    step();
    check("hold_66_a", data_output, 32'd20);
    step();
    check("hold_66_b", data_output, 32'd20);

    // Second location, no aliasing.
    drive(1'b1, 1'b0, 16'd55, 32'd1);
    step();
    drive(1'b0, 1'b1, 16'd55, 32'd0);
    step();
    check("read_55", data_output, 32'd1);
    drive(1'b0, 1'b1, 16'd66, 32'd0);
    step();
    check("reread_66", data_output, 32'd20);

    // Same-edge read and write: write-first.
    drive(1'b1, 1'b1, 16'd100, 32'hDEADBEEF);
    step();
    check("write_first", data_output, 32'hDEADBEEF);
`ifdef RAM_PARITY_EN
    check("bypass_parity", {31'd0, parity_err}, 32'd0);
`endif
    drive(1'b0, 1'b0, 16'd0, 32'd0);
    step();
    drive(1'b0, 1'b1, 16'd100, 32'd0);
    step();
    check("read_100", data_output, 32'hDEADBEEF);

    // Address boundaries and back-to-back reads.
    drive(1'b1, 1'b0, 16'd0, 32'hFFFFFFFF);
    step();
    drive(1'b1, 1'b0, 16'hFFFF, 32'h12345678);
    step();
    drive(1'b0, 1'b1, 16'd0, 32'd0);
    step();
    check("read_addr0", data_output, 32'hFFFFFFFF);
    drive(1'b0, 1'b1, 16'hFFFF, 32'd0);
    step();
    check("read_addr_max", data_output, 32'h12345678);
    drive(1'b0, 1'b1, 16'd66, 32'd0);
    step();
    check("b2b_66", data_output, 32'd20);
    drive(1'b0, 1'b1, 16'd55, 32'd0);
    step();
    check("b2b_55", data_output, 32'd1);

    // Reset mid-operation: async clear, and the concurrent write is dropped.
    drive(1'b1, 1'b1, 16'd55, 32'hAAAA5555);
    rst = 1'b0;
    #1;
    check("mid_reset_async", data_output, 32'd0);
    step();
    check("mid_reset_edge", data_output, 32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'd55, 32'd0);
    step();
    check("after_reset_idle", data_output, 32'd0);
    drive(1'b0, 1'b1, 16'd55, 32'd0);
    step();
    check("write_blocked_in_reset", data_output, 32'd1);

`ifdef RAM_PARITY_EN
    check("parity_clean_55", {31'd0, parity_err}, 32'd0);
    dut.u_array.r_mem[66] = dut.u_array.r_mem[66] ^ 33'h0000_0008;
    drive(1'b0, 1'b1, 16'd66, 32'd0);
    step();
    check("parity_flip_data", data_output, 32'd28);
    check("parity_err_66", {31'd0, parity_err}, 32'd1);
    drive(1'b0, 1'b0, 16'd0, 32'd0);
    step();
    check("parity_hold", {31'd0, parity_err}, 32'd1);
    drive(1'b0, 1'b1, 16'hFFFF, 32'd0);
    step();
    check("parity_ok_max", {31'd0, parity_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_2_16x32.md
Name: ram_2_16x32

Overview:
- Single-port synchronous RAM, 2^16 words x 32 bits, for the CPU data/instruction memory path.
- Separate write and read enables share one address bus, with separate data-in and data-out buses.
- Writes and reads complete on the rising clock edge.
- The registered read output is the only state cleared by reset.

Parameters:
- ADDR_W, 16, address width; depth = 2**ADDR_W words.
- DATA_W, 32, word width in bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears data_output (and parity_err when compiled in).
- write_enable  input  1  high: write data_input to address at the next rising edge.
- read_enable  input  1  high: load data_output from address at the next rising edge.
- address  input  ADDR_W  word address shared by reads and writes; no byte lanes.
- data_input  input  DATA_W  write data.
- data_output  output  DATA_W  registered read data.

Behaviour:
- Reset (rst low, asynchronous):
  - data_output forced to 0 immediately and held at 0 while rst is low.
  - Memory array contents are not reset; after power-up they are undefined (X in simulation).
  - Writes and reads are ignored while rst is low.
- Write:
  - On a rising edge with rst high and write_enable high, mem[address] <= data_input.
  - Write latency 0: the word is visible to any read on a later edge.
- Read:
  - On a rising edge with rst high and read_enable high, data_output <= mem[address].
  - Latency 1 cycle: data is valid after the edge that samples read_enable.
- Hold: with read_enable low, data_output keeps its last value; it never returns to 0 except by reset.
- Simultaneous read and write to the same address on one edge: write-first. data_output takes data_input, and mem is updated in the same edge.
- Both enables low: no state change.
- Address range: every value 0..65535 is valid; there is no wrap-around and no out-of-range condition.
- No handshake and no busy signal: a new operation is accepted every cycle.
- Inputs are sampled only at the rising edge; glitches between edges have no effect.
- Reset asserted mid-operation: an edge concurrent with rst low does not write; data_output reads 0 until the first read after reset release.

Optional Feature:
- Macro RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from data_input at write time.
  - A reset-to-0 output port parity_err (1 bit) is added.
  - On each read, parity_err is registered alongside data_output and is 1 when the stored parity does not match the stored data.
  - On the write-first bypass, parity_err is 0.
  - parity_err holds with data_output.
- Undefined: no parity storage and no parity_err port; behaviour is otherwise identical.

Decomposition:
- Package ram_pkg:
  - Constants ADDR_W=16, DATA_W=32, DEPTH=65536.
  - Typedefs addr_t (logic [ADDR_W-1:0]) and data_t (logic [DATA_W-1:0]).
  - Function even_parity(data_t).
- One sub-module, ram_2_16x32_array: the bare storage array with a synchronous write port and an unregistered read port, kept inferable as block RAM.
- The top level owns the output register, reset, write-first bypass and the parity logic.

Test Plan:
- Reset: hold rst low for 2 cycles with read_enable=1 -> data_output=0 throughout; release -> data_output stays 0 until the first read.
- Write then read: write 20 to address 66, then one cycle later read 66 -> data_output=20 one cycle after read_enable is sampled; drop read_enable -> data_output holds 20.
- Second location: write 1 to address 55, then read 55 -> data_output=1; re-read 66 -> still 20, showing no aliasing.
- Same-edge read and write: address 100, data_input=0xDEADBEEF, both enables high -> data_output=0xDEADBEEF after that edge; a later read of 100 -> 0xDEADBEEF.
- Boundaries: write 0xFFFFFFFF to address 0 and 0x12345678 to address 65535; read both back with exact values; back-to-back reads on consecutive cycles return each word with 1-cycle latency.
- With RAM_PARITY_EN: force-flip a stored data bit of address 66 through hierarchy, then read -> parity_err=1; read an untouched word -> parity_err=0.
